// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ctrl_pkg
// Brief   : Shared opcode, ALU_op and control-bundle definitions for the
//           decoder / control pipeline.
// Revision: 1.0 - initial release
// ============================================================================
package ctrl_pkg;

    localparam logic [5:0] c_OP_R_TYPE = 6'b000000;
    localparam logic [5:0] c_OP_SUBIU  = 6'b001101;
    localparam logic [5:0] c_OP_SW     = 6'b010000;
    localparam logic [5:0] c_OP_LW     = 6'b010001;
    localparam logic [5:0] c_OP_SLTI   = 6'b101010;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10,
        ALU_SLT   = 2'b11
    } alu_op_e;

    // Single-bit part of the bundle; ALU_op and dst are sized by the
    // instantiating module's parameters and travel alongside it.
    typedef struct packed {
        logic valid;
        logic reg_write;
        logic alu_src;
        logic mem_w;
        logic mem_r;
        logic mem_to_reg;
    } ctrl_t;

    localparam ctrl_t c_BUBBLE = '0;

endpackage
`default_nettype wire

// File: rtl/load_use_detect.sv
`default_nettype none
// ============================================================================
// Module  : load_use_detect
// Brief   : Combinational compare of the ID source registers against a load
//           sitting in EX. Used only when CTRL_PIPE_HAZARD_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
module load_use_detect #(
    parameter int REG_W = 5
) (
    input  logic             id_valid,
    input  logic             id_RegWrite,
    input  logic             id_RegDst,
    input  logic             id_Mem_w,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             ex_valid,
    input  logic             ex_mem_r,
    input  logic [REG_W-1:0] ex_dst,
    output logic             hazard
);

    logic w_rs_used;
    logic w_rt_used;

    assign w_rs_used = id_valid & (id_RegWrite | id_Mem_w);
    assign w_rt_used = id_valid & (id_RegDst   | id_Mem_w);

    // A load into r0 never produces a value, so it can never be waited on.
    assign hazard = ex_valid & ex_mem_r & (ex_dst != '0) &
                    ((w_rs_used & (ex_dst == id_rs)) |
                     (w_rt_used & (ex_dst == id_rt)));

endmodule
`default_nettype wire

// File: rtl/ctrl_pipe.sv
`default_nettype none
// ============================================================================
// Module  : ctrl_pipe
// Brief   : Carries the ID control bundle through EX/MEM/WB, resolves the
//           destination register, suppresses r0 writes and (with
//           CTRL_PIPE_HAZARD_EN defined) stalls one cycle on load-use.
// Revision: 1.0 - initial release
// ============================================================================
module ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int REG_W   = 5,
    parameter int ALUOP_W = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               id_valid,
    input  logic               id_RegDst,
    input  logic               id_RegWrite,
    input  logic               id_ALU_src,
    input  logic               id_Mem_w,
    input  logic               id_Mem_r,
    input  logic               id_Mem_to_Reg,
    input  logic [ALUOP_W-1:0] id_ALU_op,
    input  logic [REG_W-1:0]   id_rs,
    input  logic [REG_W-1:0]   id_rt,
    input  logic [REG_W-1:0]   id_rd,
    input  logic               flush,
    output logic               stall,
    output logic               ex_valid,
    output logic               ex_ALU_src,
    output logic [ALUOP_W-1:0] ex_ALU_op,
    output logic               mem_valid,
    output logic               mem_Mem_w,
    output logic               mem_Mem_r,
    output logic               wb_valid,
    output logic               wb_RegWrite,
    output logic               wb_Mem_to_Reg,
    output logic [REG_W-1:0]   wb_dst
);

    logic               w_enter;
    logic [REG_W-1:0]   w_id_dst;
    ctrl_t              w_id_ctrl;
    logic [ALUOP_W-1:0] w_id_alu_op;
    logic [REG_W-1:0]   w_id_dst_q;

    ctrl_t              r_ex;
    logic [ALUOP_W-1:0] r_ex_alu_op;
    logic [REG_W-1:0]   r_ex_dst;

    logic               r_mem_valid;
    logic               r_mem_mem_w;
    logic               r_mem_mem_r;
    logic               r_mem_reg_write;
    logic               r_mem_mem_to_reg;
    logic [REG_W-1:0]   r_mem_dst;

    logic               r_wb_valid;
    logic               r_wb_reg_write;
    logic               r_wb_mem_to_reg;
    logic [REG_W-1:0]   r_wb_dst;

`ifdef CTRL_PIPE_HAZARD_EN
    logic w_hazard;

    load_use_detect #(
        .REG_W (REG_W)
    ) u_load_use_detect (
        .id_valid    (id_valid),
        .id_RegWrite (id_RegWrite),
        .id_RegDst   (id_RegDst),
        .id_Mem_w    (id_Mem_w),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .ex_valid    (r_ex.valid),
        .ex_mem_r    (r_ex.mem_r),
        .ex_dst      (r_ex_dst),
        .hazard      (w_hazard)
    );

    // Flush wins: the ID instruction is discarded, so there is nothing to hold.
    assign stall = w_hazard & ~flush;
`else
    logic w_unused_srcs;

    assign w_unused_srcs = ^id_rs;
    assign stall         = 1'b0;
`endif

    assign w_enter  = id_valid & ~flush & ~stall;
    assign w_id_dst = id_RegDst ? id_rd : id_rt;

    always_comb begin
        w_id_ctrl   = c_BUBBLE;
        w_id_alu_op = '0;
        w_id_dst_q  = '0;
        if (w_enter) begin
            w_id_ctrl.valid      = 1'b1;
            w_id_ctrl.reg_write  = id_RegWrite & (w_id_dst != '0);
            w_id_ctrl.alu_src    = id_ALU_src;
            w_id_ctrl.mem_w      = id_Mem_w;
            w_id_ctrl.mem_r      = id_Mem_r;
            w_id_ctrl.mem_to_reg = id_Mem_to_Reg;
            w_id_alu_op          = id_ALU_op;
            w_id_dst_q           = w_id_dst;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex             <= c_BUBBLE;
            r_ex_alu_op      <= '0;
            r_ex_dst         <= '0;
            r_mem_valid      <= 1'b0;
            r_mem_mem_w      <= 1'b0;
            r_mem_mem_r      <= 1'b0;
            r_mem_reg_write  <= 1'b0;
            r_mem_mem_to_reg <= 1'b0;
            r_mem_dst        <= '0;
            r_wb_valid       <= 1'b0;
            r_wb_reg_write   <= 1'b0;
            r_wb_mem_to_reg  <= 1'b0;
            r_wb_dst         <= '0;
        end else begin
            r_ex             <= w_id_ctrl;
            r_ex_alu_op      <= w_id_alu_op;
            r_ex_dst         <= w_id_dst_q;
            r_mem_valid      <= r_ex.valid;
            r_mem_mem_w      <= r_ex.mem_w;
            r_mem_mem_r      <= r_ex.mem_r;
            r_mem_reg_write  <= r_ex.reg_write;
            r_mem_mem_to_reg <= r_ex.mem_to_reg;
            r_mem_dst        <= r_ex_dst;
            r_wb_valid       <= r_mem_valid;
            r_wb_reg_write   <= r_mem_reg_write;
            r_wb_mem_to_reg  <= r_mem_mem_to_reg;
            r_wb_dst         <= r_mem_dst;
        end
    end

    assign ex_valid      = r_ex.valid;
    assign ex_ALU_src    = r_ex.alu_src;
    assign ex_ALU_op     = r_ex_alu_op;
    assign mem_valid     = r_mem_valid;
    assign mem_Mem_w     = r_mem_mem_w;
    assign mem_Mem_r     = r_mem_mem_r;
    assign wb_valid      = r_wb_valid;
    assign wb_RegWrite   = r_wb_reg_write;
    assign wb_Mem_to_Reg = r_wb_mem_to_reg;
    assign wb_dst        = r_wb_dst;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_pipe.sv
`default_nettype none
// ============================================================================
// Module  : tb_ctrl_pipe
// Brief   : Self-checking bench for ctrl_pipe; follows CTRL_PIPE_HAZARD_EN.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ctrl_pipe;
    import ctrl_pkg::*;

`ifdef CTRL_PIPE_HAZARD_EN
    localparam bit c_HAZ = 1'b1;
`else
    localparam bit c_HAZ = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid, id_RegDst, id_RegWrite, id_ALU_src;
    logic       id_Mem_w, id_Mem_r, id_Mem_to_Reg;
    logic [1:0] id_ALU_op;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       flush;
    logic       stall;
    logic       ex_valid, ex_ALU_src;
    logic [1:0] ex_ALU_op;
    logic       mem_valid, mem_Mem_w, mem_Mem_r;
    logic       wb_valid, wb_RegWrite, wb_Mem_to_Reg;
    logic [4:0] wb_dst;

    ctrl_pipe #(.REG_W(5), .ALUOP_W(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_valid      (id_valid),
        .id_RegDst     (id_RegDst),
        .id_RegWrite   (id_RegWrite),
        .id_ALU_src    (id_ALU_src),
        .id_Mem_w      (id_Mem_w),
        .id_Mem_r      (id_Mem_r),
        .id_Mem_to_Reg (id_Mem_to_Reg),
        .id_ALU_op     (id_ALU_op),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_rd         (id_rd),
        .flush         (flush),
        .stall         (stall),
        .ex_valid      (ex_valid),
        .ex_ALU_src    (ex_ALU_src),
        .ex_ALU_op     (ex_ALU_op),
        .mem_valid     (mem_valid),
        .mem_Mem_w     (mem_Mem_w),
        .mem_Mem_r     (mem_Mem_r),
        .wb_valid      (wb_valid),
        .wb_RegWrite   (wb_RegWrite),
        .wb_Mem_to_Reg (wb_Mem_to_Reg),
        .wb_dst        (wb_dst)
    );

    always #5 clk = ~clk;

    // Reference model: an instruction record per issue slot; element k of the
    // queue is the instruction that entered the pipe k+1 edges ago.
    typedef struct {
        bit         v, rw, mtr, asrc, mw, mr;
        logic [1:0] aop;
        logic [4:0] dst;
    } ent_t;

    ent_t pipe[$];
    int   tests = 0;
    int   fails = 0;
    bit   last_stall;
    logic obs_stall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic ent_t bubble();
        ent_t e;
        e.v = 0; e.rw = 0; e.mtr = 0; e.asrc = 0; e.mw = 0; e.mr = 0;
        e.aop = 2'b00; e.dst = 5'd0;
        return e;
    endfunction

    task automatic reset_model();
        pipe.delete();
        repeat (3) pipe.push_back(bubble());
        last_stall = 0;
    endtask

    // Testbench's own main decoder for the five supported opcodes.
    task automatic set_instr(input logic [5:0] op, input logic [4:0] rs,
                             input logic [4:0] rt, input logic [4:0] rd);
        id_valid = 1; id_RegDst = 0; id_RegWrite = 0; id_ALU_src = 0;
        id_Mem_w = 0; id_Mem_r = 0; id_Mem_to_Reg = 0; id_ALU_op = 2'b00;
        id_rs = rs; id_rt = rt; id_rd = rd;
        case (op)
            c_OP_R_TYPE: begin id_RegDst = 1; id_RegWrite = 1; id_ALU_op = 2'b10; end
            c_OP_SUBIU:  begin id_RegWrite = 1; id_ALU_src = 1; id_ALU_op = 2'b01; end
            c_OP_SW:     begin id_ALU_src = 1; id_Mem_w = 1; end
            c_OP_LW:     begin id_RegWrite = 1; id_ALU_src = 1; id_Mem_r = 1; id_Mem_to_Reg = 1; end
            c_OP_SLTI:   begin id_RegWrite = 1; id_ALU_src = 1; id_ALU_op = 2'b11; end
            default:     id_valid = 0;
        endcase
    endtask

    task automatic set_idle();
        set_instr(c_OP_R_TYPE, 5'd0, 5'd0, 5'd0);
        id_valid = 0;
    endtask

    function automatic bit model_stall();
        ent_t ex = pipe[0];
        bit rs_used = id_valid && (id_RegWrite || id_Mem_w);
        bit rt_used = id_valid && (id_RegDst || id_Mem_w);
        bit haz = ex.v && ex.mr && (ex.dst != 0) &&
                  ((rs_used && ex.dst == id_rs) || (rt_used && ex.dst == id_rt));
        return c_HAZ && haz && !flush;
    endfunction

    // One clock: check all outputs mid-cycle, then advance the model at the edge.
    task automatic cycle();
        ent_t e;
        bit   exp_stall;
        @(negedge clk);
        exp_stall = model_stall();
        obs_stall = stall;
        chk("stall",         stall,         exp_stall);
        chk("ex_valid",      ex_valid,      pipe[0].v);
        chk("ex_ALU_src",    ex_ALU_src,    pipe[0].asrc);
        chk("ex_ALU_op",     ex_ALU_op,     pipe[0].aop);
        chk("mem_valid",     mem_valid,     pipe[1].v);
        chk("mem_Mem_w",     mem_Mem_w,     pipe[1].mw);
        chk("mem_Mem_r",     mem_Mem_r,     pipe[1].mr);
        chk("wb_valid",      wb_valid,      pipe[2].v);
        chk("wb_RegWrite",   wb_RegWrite,   pipe[2].rw);
        chk("wb_Mem_to_Reg", wb_Mem_to_Reg, pipe[2].mtr);
        chk("wb_dst",        wb_dst,        pipe[2].dst);
        e = bubble();
        if (id_valid && !flush && !exp_stall) begin
            e.v    = 1;
            e.dst  = id_RegDst ? id_rd : id_rt;
            e.rw   = id_RegWrite && (e.dst != 0);
            e.mtr  = id_Mem_to_Reg;
            e.asrc = id_ALU_src;
            e.mw   = id_Mem_w;
            e.mr   = id_Mem_r;
            e.aop  = id_ALU_op;
        end
        @(posedge clk);
        pipe.push_front(e);
        void'(pipe.pop_back());
        last_stall = exp_stall;
        #1;
    endtask

    // Issue one instruction, holding it while the pipe asks for a stall.
    task automatic issue(input logic [5:0] op, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd);
        int n = 0;
        set_instr(op, rs, rt, rd);
        do begin
            cycle();
            n++;
        end while (last_stall && n < 4);
        if (last_stall) chk("stall_bounded", 32'd1, 32'd0);
    endtask

    task automatic drain();
        set_idle();
        repeat (3) cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] ops [5];
        ops = '{c_OP_R_TYPE, c_OP_SUBIU, c_OP_SW, c_OP_LW, c_OP_SLTI};

        // Reset held with a valid LW presented on the ID side.
        rst_n = 0;
        flush = 0;
        set_instr(c_OP_LW, 5'd1, 5'd7, 5'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall",   stall,       0);
        chk("rst_ex",      ex_valid,    0);
        chk("rst_ex_op",   ex_ALU_op,   0);
        chk("rst_mem",     mem_valid,   0);
        chk("rst_wb",      wb_valid,    0);
        chk("rst_wb_dst",  wb_dst,      0);
        chk("rst_wb_rw",   wb_RegWrite, 0);
        reset_model();
        @(posedge clk);
        #1 rst_n = 1;

        // LW reaches WB two edges after its capture edge.
        cycle();
        set_idle();
        cycle();
        cycle();
        chk("lw_wb_valid", wb_valid,      1);
        chk("lw_wb_mtr",   wb_Mem_to_Reg, 1);
        chk("lw_wb_dst",   wb_dst,        7);

        // R_TYPE rs=1 rt=2 rd=3.
        issue(c_OP_R_TYPE, 5'd1, 5'd2, 5'd3);
        chk("rt_ex_op",  ex_ALU_op,  2'b10);
        chk("rt_ex_src", ex_ALU_src, 0);
        set_idle();
        cycle();
        cycle();
        chk("rt_wb_dst", wb_dst,      3);
        chk("rt_wb_rw",  wb_RegWrite, 1);

        // Load-use: LW rt=5 then R_TYPE rs=5.
        issue(c_OP_LW, 5'd2, 5'd5, 5'd0);
        set_instr(c_OP_R_TYPE, 5'd5, 5'd2, 5'd4);
        cycle();
        chk("lu_stall",  obs_stall, c_HAZ);
        chk("lu_bubble", ex_valid,  !c_HAZ);
        if (last_stall) cycle();
        chk("lu_issue",  ex_valid,  1);
        chk("lu_op",     ex_ALU_op, 2'b10);
        drain();

        // LW rt=5 then independent SUBIU rs=6.
        issue(c_OP_LW, 5'd2, 5'd5, 5'd0);
        set_instr(c_OP_SUBIU, 5'd6, 5'd5, 5'd0);
        cycle();
        chk("indep_stall", obs_stall, 0);
        chk("indep_ex",    ex_valid,  1);
        drain();

        // LW into r0 then a consumer of r0.
        issue(c_OP_LW, 5'd3, 5'd0, 5'd0);
        set_instr(c_OP_R_TYPE, 5'd0, 5'd0, 5'd9);
        cycle();
        chk("r0_stall", obs_stall, 0);
        set_idle();
        cycle();
        chk("r0_wb_valid", wb_valid,    1);
        chk("r0_wb_rw",    wb_RegWrite, 0);
        drain();

        // Hazard and flush in the same cycle.
        issue(c_OP_LW, 5'd2, 5'd5, 5'd0);
        set_instr(c_OP_R_TYPE, 5'd5, 5'd2, 5'd4);
        flush = 1;
        cycle();
        chk("fl_stall", obs_stall, 0);
        chk("fl_ex",    ex_valid,  0);
        flush = 0;
        drain();

        // Asynchronous reset mid-operation.
        issue(c_OP_R_TYPE, 5'd1, 5'd2, 5'd3);
        issue(c_OP_SUBIU, 5'd4, 5'd6, 5'd0);
        set_idle();
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        chk("arst_ex",  ex_valid,    0);
        chk("arst_mem", mem_valid,   0);
        chk("arst_wb",  wb_valid,    0);
        chk("arst_dst", wb_dst,      0);
        reset_model();
        @(posedge clk);
        #1 rst_n = 1;

        // Randomized traffic; inputs are held while stalled.
        for (int i = 0; i < 400; i++) begin
            if (!last_stall) begin
                set_instr(ops[$urandom_range(0, 4)], 5'($urandom_range(0, 7)),
                          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
                if ($urandom_range(0, 9) == 0) id_valid = 0;
                flush = ($urandom_range(0, 9) == 0);
            end
            cycle();
        end
        flush = 0;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
